// File: rtl/display_scanner_pkg.sv
// Shared definitions for the multiplexed display scanner.
package display_scanner_pkg;

   localparam int unsigned DEF_N_DIGITS = 4;
   localparam int unsigned DEF_DIGIT_W  = 4;
   localparam int unsigned DEF_PRESCALE = 50000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/display_scanner_tick_gen.sv
// Digit-period prescaler: counts 0..PRESCALE-1 while run, flags the last count.
module scan_tick_gen
   import display_scanner_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic tc_c
);

   localparam int unsigned    CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = (r_cnt == CNT_MAX);
   assign tc_c     = run && !clear && w_at_max;

   // Counter: clear wins, wraps to zero after the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= w_at_max ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed digit scanner with tear-free shadow update and leading-zero blanking.
module display_scanner
   import display_scanner_pkg::*;
#(
   parameter int unsigned N_DIGITS = DEF_N_DIGITS,
   parameter int unsigned DIGIT_W  = DEF_DIGIT_W,
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_DIGITS*DIGIT_W-1:0]   digits_in,
   input  logic                          load,
   input  logic                          scan_en,
   input  logic                          blank_lz,
   output logic [N_DIGITS-1:0]           digit_sel,
   output logic [DIGIT_W-1:0]            digit_val,
   output logic                          digit_blank,
   output logic                          frame_done
);

   localparam int unsigned     IDX_W    = $clog2(N_DIGITS);
   localparam int unsigned     DATA_W   = N_DIGITS * DIGIT_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic                w_wrap;
   logic                w_tc;
   logic                w_run;
   logic                w_clear;

   logic [DATA_W-1:0]   r_staging;
   logic [DATA_W-1:0]   r_shadow;
   logic [DATA_W-1:0]   w_shadow_nxt;
   logic                r_pending;
   logic                w_pending_nxt;
   logic                w_apply;
   logic                w_pend_any;
   logic [DATA_W-1:0]   w_new_data;

   logic [N_DIGITS-1:0] w_lz;
   logic                w_zero_run;
   logic [N_DIGITS-1:0] w_sel_nxt;
   logic [DIGIT_W-1:0]  w_val_nxt;
   logic                w_blank_nxt;
   logic                w_fd_nxt;

   logic [N_DIGITS-1:0] r_digit_sel;
   logic [DIGIT_W-1:0]  r_digit_val;
   logic                r_digit_blank;
   logic                r_frame_done;

   assign w_run   = (r_state == ST_SHOW) && scan_en;
   assign w_clear = !scan_en || (r_state == ST_IDLE);

   scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (w_run),
      .clear (w_clear),
      .tc_c  (w_tc)
   );

   // State and digit index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next state: SHOW for a digit period, one GAP cycle, abort to IDLE on scan_en low.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wrap      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_idx_nxt = '0;
            if (scan_en) begin
               w_state_nxt = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (!scan_en) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else if (w_tc) begin
               w_state_nxt = ST_GAP;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt = '0;
                  w_wrap    = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         ST_GAP: begin
            if (!scan_en) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_state_nxt = ST_SHOW;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Shadow update: pending data (including a same-cycle load) lands only at frame wrap or in IDLE.
   always_comb begin
      w_apply       = (r_state == ST_IDLE) || w_wrap;
      w_pend_any    = load || r_pending;
      w_new_data    = load ? digits_in : r_staging;
      w_shadow_nxt  = r_shadow;
      w_pending_nxt = w_pend_any;
      if (w_apply && w_pend_any) begin
         w_shadow_nxt  = w_new_data;
         w_pending_nxt = 1'b0;
      end
   end

   // Staging, shadow and pending registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_staging <= '0;
         r_shadow  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (load) begin
            r_staging <= digits_in;
         end
         r_shadow  <= w_shadow_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Output decode from next state so registered outputs line up with the state they describe.
   always_comb begin
      w_lz        = '0;
      w_zero_run  = 1'b1;
      w_sel_nxt   = '1;
      w_val_nxt   = '0;
      w_blank_nxt = 1'b1;
      w_fd_nxt    = w_wrap;
      for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run && (w_shadow_nxt[k*DIGIT_W +: DIGIT_W] == '0);
         w_lz[k]    = w_zero_run && (k != 0);
      end
      for (int k = 0; k < int'(N_DIGITS); k++) begin
         if ((w_state_nxt == ST_SHOW) && (w_idx_nxt == IDX_W'(k))) begin
            w_sel_nxt[k] = 1'b0;
            w_val_nxt    = w_shadow_nxt[k*DIGIT_W +: DIGIT_W];
            w_blank_nxt  = blank_lz && w_lz[k];
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit_sel   <= '1;
         r_digit_val   <= '0;
         r_digit_blank <= 1'b1;
         r_frame_done  <= 1'b0;
      end else begin
         r_digit_sel   <= w_sel_nxt;
         r_digit_val   <= w_val_nxt;
         r_digit_blank <= w_blank_nxt;
         r_frame_done  <= w_fd_nxt;
      end
   end

   assign digit_sel   = r_digit_sel;
   assign digit_val   = r_digit_val;
   assign digit_blank = r_digit_blank;
   assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with N_DIGITS=4, DIGIT_W=4, PRESCALE=4.
module tb_display_scanner;

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] val;
      logic       blank;
      logic       fd;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] digits_in;
   logic        load;
   logic        scan_en;
   logic        blank_lz;
   logic [3:0]  digit_sel;
   logic [3:0]  digit_val;
   logic        digit_blank;
   logic        frame_done;

   exp_t q[$];
   int   n_cmp;
   int   n_err;

   display_scanner #(.N_DIGITS(4), .DIGIT_W(4), .PRESCALE(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digits_in   (digits_in),
      .load        (load),
      .scan_en     (scan_en),
      .blank_lz    (blank_lz),
      .digit_sel   (digit_sel),
      .digit_val   (digit_val),
      .digit_blank (digit_blank),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t sample_dut();
      exp_t a;
      a.sel   = digit_sel;
      a.val   = digit_val;
      a.blank = digit_blank;
      a.fd    = frame_done;
      return a;
   endfunction

   // Expected idle / reset outputs.
   task automatic push_idle(input int n);
      exp_t e;
      e.sel = 4'hF; e.val = 4'h0; e.blank = 1'b1; e.fd = 1'b0;
      for (int i = 0; i < n; i++) q.push_back(e);
   endtask

   // First n cycles of a frame: each digit 4 cycles lit then one blank gap; frame_done on the last gap.
   task automatic push_frame(input logic [15:0] data, input logic [3:0] bmask, input int n);
      exp_t       e;
      logic [3:0] one;
      int         cnt;
      one = 4'b0001;
      cnt = 0;
      for (int d = 0; d < 4; d++) begin
         for (int r = 0; r < 5; r++) begin
            if (r < 4) begin
               e.sel = ~(one << d); e.val = data[d*4 +: 4]; e.blank = bmask[d]; e.fd = 1'b0;
            end else begin
               e.sel = 4'hF; e.val = 4'h0; e.blank = 1'b1; e.fd = (d == 3);
            end
            if (cnt < n) q.push_back(e);
            cnt++;
         end
      end
   endtask

   task automatic tick(input logic en, input logic ld, input logic [15:0] d);
      scan_en   = en;
      load      = ld;
      digits_in = d;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic test_reset();
      exp_t a, e;
      rst_n = 1'b0; scan_en = 1'b0; load = 1'b0; blank_lz = 1'b0; digits_in = '0;
      #12;
      a = sample_dut();
      e.sel = 4'hF; e.val = 4'h0; e.blank = 1'b1; e.fd = 1'b0;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL reset_vals: got %b want %b (sel,val,blank,fd)", a, e); end
      rst_n = 1'b1;
      push_idle(3);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 16'h0);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL reset_idle c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL reset_idle c%0d: got %b want %b", i, a, e); end end
      end
   endtask

   task automatic test_scan_order();
      exp_t a, e;
      push_idle(1); push_frame(16'h4321, 4'b0000, 20); push_frame(16'h4321, 4'b0000, 20); push_idle(1);
      for (int i = 0; i < 42; i++) begin
         tick(i >= 1 && i < 41, i == 0, 16'h4321);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL scan_order c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL scan_order c%0d: got %b want %b", i, a, e); end end
      end
   endtask

   task automatic test_tear_free();
      exp_t a, e;
      push_frame(16'h4321, 4'b0000, 20); push_frame(16'h8765, 4'b0000, 20); push_idle(1);
      for (int i = 0; i < 41; i++) begin
         tick(i < 40, i == 6, 16'h8765);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL tear_free c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL tear_free c%0d: got %b want %b", i, a, e); end end
      end
   endtask

   task automatic test_blanking();
      exp_t a, e;
      blank_lz = 1'b1;
      push_idle(1); push_frame(16'h0050, 4'b1100, 20); push_frame(16'h0000, 4'b1110, 20); push_idle(1);
      for (int i = 0; i < 42; i++) begin
         tick(i >= 1 && i < 41, i == 0 || i == 10, (i == 0) ? 16'h0050 : 16'h0000);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL blanking c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL blanking c%0d: got %b want %b", i, a, e); end end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_abort();
      exp_t a, e;
      push_idle(1); push_frame(16'h4321, 4'b0000, 12); push_idle(2);
      push_frame(16'h4321, 4'b0000, 20); push_idle(1);
      for (int i = 0; i < 36; i++) begin
         tick((i >= 1 && i <= 12) || (i >= 15 && i <= 34), i == 0, 16'h4321);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL abort c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL abort c%0d: got %b want %b", i, a, e); end end
      end
   endtask

   task automatic test_back_to_back();
      exp_t        a, e;
      logic [15:0] d;
      push_frame(16'h4321, 4'b0000, 20); push_frame(16'h9ABC, 4'b0000, 20);
      push_frame(16'h2222, 4'b0000, 20); push_idle(1);
      for (int i = 0; i < 61; i++) begin
         d = (i == 19) ? 16'h9ABC : (i == 25) ? 16'h1111 : 16'h2222;
         tick(i < 60, i == 19 || i == 25 || i == 30, d);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL back_to_back c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL back_to_back c%0d: got %b want %b", i, a, e); end end
      end
   endtask

   task automatic test_reset_mid();
      exp_t a, e;
      push_frame(16'h2222, 4'b0000, 7);
      for (int i = 0; i < 7; i++) begin
         tick(1'b1, i == 3, 16'h5555);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL reset_mid_pre c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL reset_mid_pre c%0d: got %b want %b", i, a, e); end end
      end
      e.sel = 4'hF; e.val = 4'h0; e.blank = 1'b1; e.fd = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      a = sample_dut(); n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL reset_mid_async: got %b want %b", a, e); end
      @(posedge clk); #1;
      a = sample_dut(); n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL reset_mid_hold: got %b want %b", a, e); end
      #4 rst_n = 1'b1;
      push_frame(16'h0000, 4'b0000, 20); push_frame(16'h0000, 4'b0000, 20); push_idle(1);
      for (int i = 0; i < 41; i++) begin
         tick(i < 40, 1'b0, 16'h0);
         a = sample_dut(); n_cmp++;
         if (q.size() == 0) begin n_err++; $display("FAIL reset_mid_post c%0d: queue empty got %b", i, a); end
         else begin e = q.pop_front(); if (a !== e) begin n_err++; $display("FAIL reset_mid_post c%0d: got %b want %b", i, a, e); end end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_scan_order();
      test_tear_free();
      test_blanking();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left, want 0", q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
